cmn_entry_alloc_ctrl: RTL and testbench

Entry-pool allocation controller for the common library. It owns the occupancy vector of an ENTRY_NUM-entry structure and serves up to REQ_NUM allocation requests per cycle, granting requesters strictly in order. It accepts any number of releases per cycle, supports a flush, and keeps a registered free count. Free entries are chosen from the highest index downward, which matches the multi-channel leading-one free finder it instantiates.

---
 rtl/cmn_entry_alloc_ctrl.sv | 136 +++++++++++++
 tb/tb_cmn_entry_alloc_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cmn_entry_alloc_ctrl.sv
// cmn_entry_alloc_ctrl: allocation controller for a pool of ENTRY_NUM entries.
// It grants up to REQ_NUM in-order requests per cycle. Free entries are handed
// out from the highest index downward. It also handles multi-entry releases, a
// flush and a registered free count.
// Optional feature macro: CMN_ALLOC_REL_BYPASS_EN. When it is defined, an entry
// released this cycle can be granted again in the same cycle.
module cmn_entry_alloc_ctrl #(
    parameter int ENTRY_NUM = 16,
    parameter int REQ_NUM   = 4,
    localparam int AWIDTH   = $clog2(ENTRY_NUM),
    localparam int CWIDTH   = $clog2(ENTRY_NUM + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM-1:0]            alloc_req,
    output logic [REQ_NUM-1:0]            alloc_gnt,
    output logic [ENTRY_NUM*REQ_NUM-1:0]  alloc_idx_oh,
    output logic [AWIDTH*REQ_NUM-1:0]     alloc_idx_bin,
    input  logic                          rel_vld,
    input  logic [ENTRY_NUM-1:0]          rel_mask,
    input  logic                          flush,
    output logic [ENTRY_NUM-1:0]          occ_vec,
    output logic [CWIDTH-1:0]             free_cnt,
    output logic                          full,
    output logic                          empty,
    output logic                          rel_err
);

    logic [ENTRY_NUM-1:0]              eff_rel;
    logic [ENTRY_NUM-1:0]              free_vec;
    logic [REQ_NUM-1:0][ENTRY_NUM-1:0] slot_oh;
    logic [REQ_NUM-1:0][AWIDTH-1:0]    slot_bin;
    logic [REQ_NUM-1:0]                slot_vld;
    logic [ENTRY_NUM-1:0]              alloc_mask;
    logic [ENTRY_NUM-1:0]              occ_next;
    logic [CWIDTH-1:0]                 rel_pop;
    logic [CWIDTH-1:0]                 gnt_pop;
    logic [CWIDTH-1:0]                 free_cnt_next;
    logic                              rel_bad;

    // Effective release set, release-error detection and the finder input vector
    always_comb begin
        eff_rel = rel_vld ? (rel_mask & occ_vec) : '0;
        rel_bad = rel_vld && |(rel_mask & ~occ_vec);
`ifdef CMN_ALLOC_REL_BYPASS_EN
        free_vec = ~occ_vec | eff_rel;
`else
        free_vec = ~occ_vec;
`endif
    end

    // Multi-channel leading-one finder: slot n is the n-th highest free index
    always_comb begin
        int unsigned n;
        slot_oh  = '0;
        slot_bin = '0;
        slot_vld = '0;
        n        = 0;
        for (int unsigned i = ENTRY_NUM; i > 0; i--) begin
            if (free_vec[i-1] && (n < REQ_NUM)) begin
                slot_oh[n][i-1] = 1'b1;
                slot_bin[n]     = AWIDTH'(i - 1);
                slot_vld[n]     = 1'b1;
                n++;
            end
        end
    end

    // In-order grant: the m-th granted channel takes slot m; first refusal blocks the rest
    always_comb begin
        int unsigned m;
        logic        blocked;
        alloc_gnt     = '0;
        alloc_idx_oh  = '0;
        alloc_idx_bin = '0;
        alloc_mask    = '0;
        m             = 0;
        blocked       = flush;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            if (alloc_req[k]) begin
                if (!blocked && slot_vld[m]) begin
                    alloc_gnt[k]                          = 1'b1;
                    alloc_idx_oh[k*ENTRY_NUM +: ENTRY_NUM] = slot_oh[m];
                    alloc_idx_bin[k*AWIDTH +: AWIDTH]     = slot_bin[m];
                    alloc_mask                            = alloc_mask | slot_oh[m];
                    m++;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    // Next occupancy and net free-count change
    always_comb begin
        rel_pop = '0;
        gnt_pop = '0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            rel_pop = rel_pop + CWIDTH'(eff_rel[i]);
        end
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            gnt_pop = gnt_pop + CWIDTH'(alloc_gnt[k]);
        end
        // A bypassed entry that is released and re-granted stays set and nets to zero in the count
        occ_next      = (occ_vec & ~eff_rel) | alloc_mask;
        free_cnt_next = free_cnt + rel_pop - gnt_pop;
    end

    // State register: reset, then flush, then normal alloc/release update
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_vec  <= '0;
            free_cnt <= CWIDTH'(ENTRY_NUM);
            full     <= 1'b0;
            empty    <= 1'b1;
            rel_err  <= 1'b0;
        end else if (flush) begin
            occ_vec  <= '0;
            free_cnt <= CWIDTH'(ENTRY_NUM);
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            occ_vec  <= occ_next;
            free_cnt <= free_cnt_next;
            full     <= (free_cnt_next == '0);
            empty    <= (free_cnt_next == CWIDTH'(ENTRY_NUM));
            if (rel_bad) begin
                rel_err <= 1'b1;
            end
        end
    end

    cnt_consistent: assert property (@(posedge clk) disable iff (rst)
        int'(free_cnt) == ENTRY_NUM - $countones(occ_vec));

endmodule

// File: tb/tb_cmn_entry_alloc_ctrl.sv
// Self-checking bench for cmn_entry_alloc_ctrl: a table of directed vectors
// followed by random traffic, all checked against a free-list reference model.
module tb_cmn_entry_alloc_ctrl;
    localparam int EN = 16;
    localparam int RN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [RN-1:0] alloc_req;
    logic [RN-1:0] alloc_gnt;
    logic [EN*RN-1:0] alloc_idx_oh;
    logic [4*RN-1:0]  alloc_idx_bin;
    logic          rel_vld;
    logic [EN-1:0] rel_mask;
    logic          flush;
    logic [EN-1:0] occ_vec;
    logic [4:0]    free_cnt;
    logic          full, empty, rel_err;

    always #5 clk = ~clk;

    cmn_entry_alloc_ctrl #(.ENTRY_NUM(EN), .REQ_NUM(RN)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_idx_oh(alloc_idx_oh), .alloc_idx_bin(alloc_idx_bin),
        .rel_vld(rel_vld), .rel_mask(rel_mask), .flush(flush),
        .occ_vec(occ_vec), .free_cnt(free_cnt), .full(full), .empty(empty),
        .rel_err(rel_err)
    );

    typedef struct {
        logic        r;
        logic [3:0]  req;
        logic        rv;
        logic [15:0] rm;
        logic        fl;
        logic [3:0]  e_gnt;
        logic [15:0] e_bin;
        logic        chk;
        logic [15:0] e_occ;
        logic [4:0]  e_cnt;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    bit [15:0] m_occ   = '0;
    bit        m_err   = 1'b0;
    bit        m_valid = 1'b0;

    function automatic vec_t mk(logic r, logic [3:0] req, logic rv, logic [15:0] rm,
                                logic fl, logic [3:0] eg, logic [15:0] eb, logic chk,
                                logic [15:0] eo, logic [4:0] ec, logic ee);
        vec_t v;
        v.r = r; v.req = req; v.rv = rv; v.rm = rm; v.fl = fl;
        v.e_gnt = eg; v.e_bin = eb; v.chk = chk; v.e_occ = eo; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input bit use_tbl);
        int        q[$];
        bit        blocked;
        bit [3:0]  mg;
        bit [15:0] mb;
        bit [63:0] mo;
        bit [15:0] gmask;
        bit [15:0] rel;
        int        e_free;
        rst = v.r; alloc_req = v.req; rel_vld = v.rv; rel_mask = v.rm; flush = v.fl;
        @(negedge clk);
        // Reference: free entries listed highest first, handed out to requesters in order
        q = {};
        for (int i = EN - 1; i >= 0; i--) begin
`ifdef CMN_ALLOC_REL_BYPASS_EN
            if (!m_occ[i] || (v.rv && v.rm[i])) q.push_back(i);
`else
            if (!m_occ[i]) q.push_back(i);
`endif
        end
        mg = '0; mb = '0; mo = '0; gmask = '0;
        blocked = v.fl;
        for (int k = 0; k < RN; k++) begin
            if (v.req[k]) begin
                if (!blocked && q.size() > 0) begin
                    int e;
                    e = q.pop_front();
                    mg[k] = 1'b1;
                    mb[k*4 +: 4] = 4'(e);
                    mo[k*EN + e] = 1'b1;
                    gmask[e] = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
        e_free = EN - $countones(m_occ);
        if (m_valid) begin
            check("mdl_gnt", 64'(alloc_gnt), 64'(mg));
            check("mdl_oh", alloc_idx_oh, mo);
            check("mdl_bin", 64'(alloc_idx_bin), 64'(mb));
            check("mdl_occ", 64'(occ_vec), 64'(m_occ));
            check("mdl_cnt", 64'(free_cnt), 64'(e_free));
            check("mdl_full", 64'(full), 64'(e_free == 0));
            check("mdl_empty", 64'(empty), 64'(e_free == EN));
            check("mdl_err", 64'(rel_err), 64'(m_err));
        end
        if (use_tbl) begin
            check("tbl_gnt", 64'(alloc_gnt), 64'(v.e_gnt));
            check("tbl_bin", 64'(alloc_idx_bin), 64'(v.e_bin));
            if (v.chk) begin
                check("tbl_occ", 64'(occ_vec), 64'(v.e_occ));
                check("tbl_cnt", 64'(free_cnt), 64'(v.e_cnt));
                check("tbl_full", 64'(full), 64'(v.e_cnt == 0));
                check("tbl_empty", 64'(empty), 64'(v.e_cnt == 5'd16));
                check("tbl_err", 64'(rel_err), 64'(v.e_err));
            end
        end
        @(posedge clk);
        #1;
        if (v.r) begin
            m_occ = '0; m_err = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (v.fl) begin
                m_occ = '0;
            end else begin
                rel = v.rv ? (v.rm & m_occ) : '0;
                if (v.rv && ((v.rm & ~m_occ) != 0)) m_err = 1'b1;
                m_occ = (m_occ & ~rel) | gmask;
            end
        end
    endtask

    initial begin
        vec_t v;
        // r req rv rm fl | gnt bin | chk occ cnt err
        tbl.push_back(mk(1, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 0, 16'h0000, 5'd16, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 4'hF, 16'hCDEF, 1, 16'h0000, 5'd16, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'hF000, 5'd12, 0));
        tbl.push_back(mk(1, 4'h5, 0, 16'h0000, 0, 4'h5, 16'h0A0B, 1, 16'hF000, 5'd12, 0));
        tbl.push_back(mk(0, 4'h5, 0, 16'h0000, 0, 4'h5, 16'h0E0F, 1, 16'h0000, 5'd16, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'hC000, 5'd14, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 4'hF, 16'hABCD, 1, 16'hC000, 5'd14, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 4'hF, 16'h6789, 1, 16'hFC00, 5'd10, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 4'hF, 16'h2345, 1, 16'hFFC0, 5'd6, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 4'h3, 16'h0001, 1, 16'hFFFC, 5'd2, 0));
        tbl.push_back(mk(0, 4'h1, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'hFFFF, 5'd0, 0));
`ifdef CMN_ALLOC_REL_BYPASS_EN
        tbl.push_back(mk(0, 4'h1, 1, 16'h0011, 0, 4'h1, 16'h0004, 1, 16'hFFFF, 5'd0, 0));
        tbl.push_back(mk(0, 4'h1, 0, 16'h0000, 0, 4'h1, 16'h0000, 1, 16'hFFFE, 5'd1, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 1, 4'h0, 16'h0000, 1, 16'hFFFF, 5'd0, 0));
`else
        tbl.push_back(mk(0, 4'h1, 1, 16'h0011, 0, 4'h0, 16'h0000, 1, 16'hFFFF, 5'd0, 0));
        tbl.push_back(mk(0, 4'h1, 0, 16'h0000, 0, 4'h1, 16'h0004, 1, 16'hFFEE, 5'd2, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 1, 4'h0, 16'h0000, 1, 16'hFFFE, 5'd1, 0));
`endif
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'h0000, 5'd16, 0));
        tbl.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 4'hF, 16'hCDEF, 1, 16'h0000, 5'd16, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h1001, 0, 4'h0, 16'h0000, 1, 16'hF000, 5'd12, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'hE000, 5'd13, 1));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'hE000, 5'd13, 1));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 1, 4'h0, 16'h0000, 1, 16'hE000, 5'd13, 1));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'h0000, 5'd16, 1));
        tbl.push_back(mk(1, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'h0000, 5'd16, 1));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'h0000, 5'd16, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

        for (int i = 0; i < 600; i++) begin
            v = mk(0, 4'h0, 0, 16'h0000, 0, 4'h0, 16'h0000, 0, 16'h0000, 5'd0, 0);
            v.r   = ($urandom_range(0, 99) == 0);
            v.fl  = ($urandom_range(0, 39) == 0);
            v.req = 4'($urandom);
            v.rv  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) v.rm = 16'($urandom);
            else v.rm = 16'($urandom) & m_occ;
            step(v, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
